// File: rtl/uart_kbd_rx_if.sv
// Keyboard buffer handshake between the serial receiver and the PIA keyboard port.
interface uart_kbd_rx_if;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ack;

  // Receiver side: presents the buffered key and takes the consume pulse.
  modport master (
    output kbd_data,
    output kbd_valid,
    input  kbd_ack
  );

  // PIA side: reads the buffered key and pulses ack once consumed.
  modport slave (
    input  kbd_data,
    input  kbd_valid,
    output kbd_ack
  );
endinterface

// File: rtl/uart_kbd_rx.sv
// Apple-1 serial keyboard front-end: 8N1 receiver, key mapping, one-entry
// key buffer with valid/ack handshake and CTS flow control.
module uart_kbd_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter bit UPCASE       = 1'b1,
  parameter bit SET_B7       = 1'b1
) (
  input  logic           clk25,
  input  logic           rst,
  input  logic           uart_rx_i,
  uart_kbd_rx_if.master  kbd,
  output logic           uart_cts_o,
  output logic           frame_err_o,
  output logic           overrun_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          deliver;
  logic [7:0]    key;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  // Two-flop synchronizer; resets to idle-high so no false start edge appears.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state, counters, shift register and the registered frame error pulse.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Receiver next state: start is confirmed at mid-bit, data and stop sampled a full bit later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Key mapping: optional upper-case folding and the Apple-1 high-bit convention.
  always_comb begin
    key = shift_q;
    if (UPCASE && (shift_q >= 8'h61) && (shift_q <= 8'h7A)) begin
      key[5] = 1'b0;
    end
    if (SET_B7) begin
      key[7] = 1'b1;
    end
  end

  // Buffer update: an ack arriving with a new key frees the slot for it, otherwise the key is dropped.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (deliver) begin
      if (!valid_q || kbd.kbd_ack) begin
        data_d  = key;
        valid_d = 1'b1;
        if (kbd.kbd_ack) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (kbd.kbd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign kbd.kbd_data  = data_q;
  assign kbd.kbd_valid = valid_q;
  assign uart_cts_o    = valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_kbd_rx.sv
// Self-checking bench for uart_kbd_rx: two instances (mapping on / mapping off)
// share one serial line and one ack, compared against a key-level buffer model.
module tb_uart_kbd_rx;

  localparam int CPB = 8;

  logic clk25  = 1'b0;
  logic rst    = 1'b1;
  logic uartRx = 1'b1;
  logic kbdAck = 1'b0;
  logic ctsA, feA, ovA;
  logic ctsB, feB, ovB;

  int compareCount  = 0;
  int mismatchCount = 0;
  int feCountA      = 0;
  int feCountB      = 0;

  bit         expValid   = 1'b0;
  bit         expOverrun = 1'b0;
  logic [7:0] expDataA   = 8'h00;
  logic [7:0] expDataB   = 8'h00;
  int         expFe      = 0;

  uart_kbd_rx_if busA ();
  uart_kbd_rx_if busB ();

  assign busA.kbd_ack = kbdAck;
  assign busB.kbd_ack = kbdAck;

  uart_kbd_rx #(.CLKS_PER_BIT(CPB), .UPCASE(1'b1), .SET_B7(1'b1)) dutA (
    .clk25       (clk25),
    .rst         (rst),
    .uart_rx_i   (uartRx),
    .kbd         (busA),
    .uart_cts_o  (ctsA),
    .frame_err_o (feA),
    .overrun_o   (ovA)
  );

  uart_kbd_rx #(.CLKS_PER_BIT(CPB), .UPCASE(1'b0), .SET_B7(1'b0)) dutB (
    .clk25       (clk25),
    .rst         (rst),
    .uart_rx_i   (uartRx),
    .kbd         (busB),
    .uart_cts_o  (ctsB),
    .frame_err_o (feB),
    .overrun_o   (ovB)
  );

  // 100 MHz-style free-running clock for the bench.
  always #5 clk25 = ~clk25;

  // Count every cycle in which frame_err is seen high, to check pulse count and width.
  always @(negedge clk25) begin
    if (!rst) begin
      if (feA) feCountA++;
      if (feB) feCountB++;
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] mapKey(input logic [7:0] b, input bit up, input bit b7);
    int v;
    v = int'(b);
    if (up && v >= 97 && v <= 122) v = v - 32;
    if (b7 && v < 128) v = v + 128;
    return 8'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkState(input string where);
    checkOutput($sformatf("%s validA", where), 32'(busA.kbd_valid), 32'(expValid));
    checkOutput($sformatf("%s validB", where), 32'(busB.kbd_valid), 32'(expValid));
    checkOutput($sformatf("%s ctsA", where), 32'(ctsA), 32'(expValid));
    checkOutput($sformatf("%s ctsB", where), 32'(ctsB), 32'(expValid));
    checkOutput($sformatf("%s dataA", where), 32'(busA.kbd_data), 32'(expDataA));
    checkOutput($sformatf("%s dataB", where), 32'(busB.kbd_data), 32'(expDataB));
    checkOutput($sformatf("%s overrunA", where), 32'(ovA), 32'(expOverrun));
    checkOutput($sformatf("%s overrunB", where), 32'(ovB), 32'(expOverrun));
    checkOutput($sformatf("%s ferrCountA", where), 32'(feCountA), 32'(expFe));
    checkOutput($sformatf("%s ferrCountB", where), 32'(feCountB), 32'(expFe));
  endtask

  task automatic modelReset();
    expValid   = 1'b0;
    expOverrun = 1'b0;
    expDataA   = 8'h00;
    expDataB   = 8'h00;
  endtask

  // Key-level model of one complete frame reaching the buffer.
  task automatic modelFrame(input logic [7:0] b, input bit stopOk, input bit ackDel);
    if (stopOk) begin
      if (!expValid || ackDel) begin
        expDataA = mapKey(b, 1'b1, 1'b1);
        expDataB = mapKey(b, 1'b0, 1'b0);
        expValid = 1'b1;
        if (ackDel) expOverrun = 1'b0;
      end else begin
        expOverrun = 1'b1;
      end
    end else begin
      expFe++;
      if (ackDel && expValid) begin
        expValid   = 1'b0;
        expOverrun = 1'b0;
      end
    end
  endtask

  // Drive one 8N1 frame. The ack pulse, when requested, lands on the stop-sample
  // cycle: two synchronizer flops plus the IDLE detect cycle put that sample on the
  // seventh rising edge inside the stop bit. abortBit >= 0 resets mid data bit.
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit ackDel,
                               input int lowHold, input int abortBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int pos = 0; pos < 10; pos++) begin
      uartRx = frame[pos];
      for (int c = 0; c < CPB; c++) begin
        if (abortBit >= 0 && pos == abortBit + 1 && c == CPB / 2) begin
          rst    = 1'b1;
          uartRx = 1'b1;
          modelReset();
          repeat (2) @(negedge clk25);
          checkState("midframe reset");
          rst = 1'b0;
          repeat (4) @(negedge clk25);
          return;
        end
        if (pos == 9 && ackDel && c == CPB - 2) kbdAck = 1'b1;
        if (pos == 9 && ackDel && c == CPB - 1) kbdAck = 1'b0;
        @(negedge clk25);
      end
    end
    kbdAck = 1'b0;
    repeat (lowHold) @(negedge clk25);
    uartRx = 1'b1;
    modelFrame(b, stopBit, ackDel);
  endtask

  task automatic sendAndCheck(input logic [7:0] b, input bit stopBit, input bit ackDel,
                              input int lowHold, input string tag);
    applyStimulus(b, stopBit, ackDel, lowHold, -1);
    repeat (3 + $urandom_range(0, 3)) @(negedge clk25);
    checkState(tag);
  endtask

  task automatic pulseAck(input string tag);
    kbdAck = 1'b1;
    @(negedge clk25);
    kbdAck = 1'b0;
    if (expValid) begin
      expValid   = 1'b0;
      expOverrun = 1'b0;
    end
    checkState(tag);
  endtask

  task automatic glitch(input int len, input string tag);
    uartRx = 1'b0;
    repeat (len) @(negedge clk25);
    uartRx = 1'b1;
    repeat (12) @(negedge clk25);
    checkState(tag);
  endtask

  // Directed scenarios first, then a randomized mix of frames, acks and glitches.
  initial begin
    logic [7:0] rb;
    bit         rStop;
    bit         rAck;
    int         rHold;
    int         sel;

    rst = 1'b1;
    repeat (3) @(negedge clk25);
    checkState("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk25);

    sendAndCheck(8'h41, 1'b1, 1'b0, 0, "upper A");
    checkOutput("spot A mapped", 32'(busA.kbd_data), 32'h00C1);
    checkOutput("spot A raw", 32'(busB.kbd_data), 32'h0041);
    pulseAck("ack A");

    sendAndCheck(8'h61, 1'b1, 1'b0, 0, "lower a");
    checkOutput("spot a mapped", 32'(busA.kbd_data), 32'h00C1);
    checkOutput("spot a raw", 32'(busB.kbd_data), 32'h0061);
    pulseAck("ack a");

    glitch(2, "glitch 2");

    sendAndCheck(8'h0D, 1'b0, 1'b0, 40, "break");
    checkOutput("spot break one pulse", 32'(feCountA), 32'd1);
    sendAndCheck(8'h31, 1'b1, 1'b0, 0, "after break");
    checkOutput("spot 1 mapped", 32'(busA.kbd_data), 32'h00B1);
    pulseAck("ack 1");

    sendAndCheck(8'h41, 1'b1, 1'b0, 0, "fill A");
    sendAndCheck(8'h42, 1'b1, 1'b0, 0, "overrun B");
    checkOutput("spot overrun", 32'(ovA), 32'd1);
    sendAndCheck(8'h43, 1'b1, 1'b1, 0, "ack on delivery C");
    checkOutput("spot C mapped", 32'(busA.kbd_data), 32'h00C3);

    applyStimulus(8'h99, 1'b1, 1'b0, 0, 4);
    sendAndCheck(8'h5A, 1'b1, 1'b0, 0, "after reset Z");
    checkOutput("spot Z mapped", 32'(busA.kbd_data), 32'h00DA);
    pulseAck("ack Z");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        glitch($urandom_range(1, 3), $sformatf("rnd%0d glitch", i));
      end else if (sel < 3) begin
        pulseAck($sformatf("rnd%0d ack", i));
      end else begin
        rb    = 8'($urandom);
        rStop = ($urandom_range(0, 7) != 0);
        rAck  = rStop && ($urandom_range(0, 2) == 0);
        rHold = rStop ? 0 : $urandom_range(0, 20);
        sendAndCheck(rb, rStop, rAck, rHold, $sformatf("rnd%0d frame %02h", i, rb));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/uart_kbd_rx.md
Name: uart_kbd_rx

Overview:
- Serial keyboard front-end of the Apple-1 core: receives 8N1 bytes on the board `uart_rx` pin.
- Maps each byte to Apple-1 keyboard format and holds it in a one-entry buffer.
- Buffer is read by the keyboard PIA port through a valid/ack handshake.
- Drives `uart_cts` so the host stops sending while a key is still unread.

Parameters:
- CLKS_PER_BIT, 217, clk25 cycles per bit (25 MHz / 115200); minimum 4.
- UPCASE, 1, when 1 fold lowercase 0x61-0x7A to uppercase by clearing bit 5.
- SET_B7, 1, when 1 force kbd_data[7]=1 (Apple-1 keyboard convention).

Ports:
- clk25  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- kbd_ack  in  1  one-cycle pulse from PIA: buffered key consumed.
- kbd_data  out  8  buffered key code.
- kbd_valid  out  1  buffer holds an unread key.
- uart_cts  out  1  flow control, 1 = hold off; equals kbd_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: byte arrived while buffer full; cleared by kbd_ack.

Behaviour:
- Reset values:
  - kbd_data=0x00, kbd_valid=0, uart_cts=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, FSM=IDLE, bit counter=0, cycle counter=0.
- Input path: uart_rx passes a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- HALF = CLKS_PER_BIT/2, using integer division.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: cnt increments; at cnt==HALF-1, sample rx_s.
    - 0 -> DATA, cnt=0, bit index=0.
    - 1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into bit[idx] (LSB first), cnt=0, idx++.
    - After bit 7 is sampled -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> deliver the byte, then IDLE.
    - 0 -> frame_err=1 for exactly one cycle, byte discarded, then WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. A break condition must not produce repeated frames.
- Mapping, applied at delivery: b = received byte.
  - If UPCASE and 0x61<=b<=0x7A, then b[5]=0.
  - If SET_B7, then b[7]=1.
- Delivery takes effect in the clock edge after the stop-bit sample. kbd_valid rises 1 cycle after the STOP sample cycle.
  - Buffer empty: kbd_data<=b, kbd_valid<=1.
  - Buffer full and no kbd_ack that cycle: byte dropped, kbd_data unchanged, overrun<=1.
  - Buffer full with kbd_ack in the same cycle: kbd_data<=b, kbd_valid stays 1, overrun not set.
- kbd_ack with no delivery: kbd_valid<=0, overrun<=0. kbd_ack while kbd_valid==0 is ignored.
- kbd_data holds its last value after ack; consumers qualify it with kbd_valid.
- Reception is unaffected by buffer state. The receiver never stalls; only the buffer overruns.
- rst asserted mid-frame: immediate return to reset values. The partial byte is lost. After release, a new frame is recognized only on a fresh falling edge of rx_s.
- Counter widths sized by $clog2(CLKS_PER_BIT). Counters never wrap within a state.

Test Plan:
- Bench runs CLKS_PER_BIT=8, UPCASE=1, SET_B7=1 unless stated.
- Send 0x41 ('A', 8N1) -> one frame after the stop sample, kbd_valid=1, kbd_data=0xC1, uart_cts=1, frame_err=0; pulse kbd_ack -> kbd_valid=0, uart_cts=0 next cycle.
- Send 0x61 ('a') -> kbd_data=0xC1. Repeat with UPCASE=0, SET_B7=0 -> kbd_data=0x61.
- Low glitch of 2 cycles on an idle line -> FSM returns to IDLE; kbd_valid, frame_err and overrun stay 0.
- Send 0x0D with stop bit forced low, then hold the line low for 40 cycles -> exactly one frame_err pulse, kbd_valid=0. Line high, then send 0x31 -> kbd_data=0xB1.
- Send 0x41 then 0x42 with no ack -> kbd_data=0xC1, overrun=1. Send 0x43 with kbd_ack on its delivery cycle -> kbd_data=0xC3, kbd_valid=1, overrun=0.
- Assert rst during bit 4 of a frame -> all outputs at reset values. Release rst, then send 0x5A -> kbd_data=0xDA.
